pit26_timer: RTL and testbench



---
 rtl/pit26_timer.sv | 54 +++++
 tb/tb_pit26_timer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pit26_timer.sv
// pit26_timer: 26-bit interval timer with reload, periodic tick and sticky irq.
// Define PIT26_PRESCALE_EN to add the 8-bit prescaler and the psc port.
module pit26_timer (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        ld_reload,
  input  logic [25:0] din,
  input  logic        start,
  input  logic        stop,
  input  logic        irq_ack,
`ifdef PIT26_PRESCALE_EN
  input  logic [7:0]  psc,
`endif
  input  logic        zero,
  output logic [25:0] count,
  output logic        running,
  output logic        tick,
  output logic        irq_pend
);
  logic [25:0] rld, rld_nx, count_nx;
  logic        run_nx, en, expire, irq_nx;
`ifdef PIT26_PRESCALE_EN
  logic [7:0] p, p_nx;
  assign en   = running & ~stop & (p == psc);
  assign p_nx = start ? 8'd0 : (running & ~stop) ? ((p == psc) ? 8'd0 : p + 8'd1) : p;
  always_ff @(posedge sys_clk or negedge resetl)
    if (!resetl) p <= '0;
    else p <= p_nx;
`else
  assign en = running & ~stop;
`endif
  // zero comes from the external zero-detect stage; the expiry reloads the pre-write R
  assign expire = en & zero & ~start;
  always_comb begin
    rld_nx   = ld_reload ? din : rld;
    count_nx = start ? rld_nx : (ld_reload & ~running) ? din : expire ? rld : en ? count - 26'd1 : count;
    run_nx   = start ? ~stop : stop ? 1'b0 : running;
    irq_nx   = expire | (irq_pend & ~irq_ack);
  end
  always_ff @(posedge sys_clk or negedge resetl)
    if (!resetl) begin
      count    <= '0;
      rld      <= '0;
      running  <= 1'b0;
      tick     <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      count    <= count_nx;
      rld      <= rld_nx;
      running  <= run_nx;
      tick     <= expire;
      irq_pend <= irq_nx;
    end
endmodule

// File: tb/tb_pit26_timer.sv
// tb_pit26_timer: random and directed checks of pit26_timer against a period-level model.
module tb_pit26_timer;
  logic        sys_clk, resetl, ld_reload, start, stop, irq_ack;
  logic [25:0] din;
  logic [25:0] count;
  logic        running, tick, irq_pend;
  logic        zero;
`ifdef PIT26_PRESCALE_EN
  logic [7:0]  psc;
`endif
  int n_tests, n_fail;
  logic [25:0] m_base, m_r;
  int          m_k, m_p;
  logic        m_run, m_tick, m_irq;

  assign zero = (count == 26'd0);

  pit26_timer dut (
    .sys_clk(sys_clk), .resetl(resetl), .ld_reload(ld_reload), .din(din),
    .start(start), .stop(stop), .irq_ack(irq_ack),
`ifdef PIT26_PRESCALE_EN
    .psc(psc),
`endif
    .zero(zero), .count(count), .running(running), .tick(tick), .irq_pend(irq_pend)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_base = '0; m_r = '0; m_k = 0; m_p = 0;
    m_run = 1'b0; m_tick = 1'b0; m_irq = 1'b0;
  endtask

  // count = base - k, where base is the value loaded at period start and k the enabled cycles since
  task automatic step();
    logic term, en;
    @(posedge sys_clk);
    term = 1'b1;
`ifdef PIT26_PRESCALE_EN
    term = (m_p == int'(psc));
    if (start) m_p = 0;
    else if (m_run && !stop) m_p = (m_p + 1) % (int'(psc) + 1);
`endif
    en = m_run && !stop && term;
    m_tick = 1'b0;
    if (start) begin
      m_base = ld_reload ? din : m_r;
      m_k = 0;
    end else if (ld_reload && !m_run) begin
      m_base = din;
      m_k = 0;
    end else if (en) begin
      if (m_k == int'(m_base)) begin
        m_base = m_r;
        m_k = 0;
        m_tick = 1'b1;
      end else m_k++;
    end
    if (ld_reload) m_r = din;
    m_irq = m_tick | (m_irq & !irq_ack);
    if (start || stop) m_run = start && !stop;
    #1;
    chk("state", {3'b0, count, running, tick, irq_pend},
        {3'b0, 26'(m_base - 26'(m_k)), m_run, m_tick, m_irq});
  endtask

  task automatic cyc(input logic st, input logic sp, input logic ld, input logic ack, input logic [25:0] d);
    start = st; stop = sp; ld_reload = ld; irq_ack = ack; din = d;
    step();
    start = 0; stop = 0; ld_reload = 0; irq_ack = 0;
  endtask

  task automatic wait_tick(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 2000);
    chk(tag, n, exp);
  endtask

  initial begin
    logic [25:0] seq [6];
    n_tests = 0; n_fail = 0;
    resetl = 0; start = 0; stop = 0; ld_reload = 0; irq_ack = 0; din = '0;
`ifdef PIT26_PRESCALE_EN
    psc = 8'd0;
`endif
    model_reset();
    repeat (2) @(negedge sys_clk);
    resetl = 1;
    #1;
    chk("reset_state", {count, running, tick, irq_pend}, 29'd0);

    // periodic tick with R=4
    cyc(0, 0, 1, 0, 26'd4);
    cyc(1, 0, 0, 0, 26'd0);
    chk("start_count", count, 26'd4);
    chk("start_running", running, 1);
    seq = '{26'd3, 26'd2, 26'd1, 26'd0, 26'd4, 26'd3};
    for (int i = 0; i < 6; i++) begin
      step();
      chk("r4_seq", count, seq[i]);
      chk("r4_tick", tick, (i == 4));
      chk("r4_irq", irq_pend, (i >= 4));
    end
    wait_tick("r4_period", 4);
    wait_tick("r4_period", 5);

    // R=0: tick every cycle, irq_ack loses to a same-cycle set
    cyc(0, 1, 0, 0, 26'd0);
    cyc(0, 0, 1, 1, 26'd0);
    chk("ack_clear", irq_pend, 0);
    cyc(1, 0, 0, 0, 26'd0);
    for (int i = 0; i < 3; i++) wait_tick("r0_period", 1);
    cyc(0, 0, 0, 1, 26'd0);
    chk("ack_vs_set", irq_pend, 1);
    chk("r0_count", count, 26'd0);

    // full range: reload to max only through expiry
    cyc(0, 0, 1, 0, 26'h3FFFFFF);
    step();
    chk("max_reload", count, 26'h3FFFFFF);
    chk("max_tick", tick, 1);
    step();
    chk("max_dec", count, 26'h3FFFFFE);

    // start and stop together
    cyc(0, 1, 0, 0, 26'd0);
    cyc(0, 0, 1, 0, 26'd5);
    cyc(1, 0, 0, 0, 26'd0);
    repeat (2) step();
    cyc(1, 1, 0, 0, 26'd0);
    chk("startstop_run", running, 0);
    chk("startstop_cnt", count, 26'd5);
    step();
    chk("stop_hold", count, 26'd5);

    // ld_reload with start
    cyc(1, 0, 1, 0, 26'd9);
    wait_tick("ldstart_period", 10);
    wait_tick("ldstart_period2", 10);

    // reload while running
    cyc(0, 1, 0, 0, 26'd0);
    cyc(0, 0, 1, 0, 26'd3);
    cyc(1, 0, 0, 0, 26'd0);
    cyc(0, 0, 1, 0, 26'd7);
    wait_tick("rl_first_rest", 3);
    wait_tick("rl_next", 8);
    wait_tick("rl_next", 8);

`ifdef PIT26_PRESCALE_EN
    cyc(0, 1, 0, 0, 26'd0);
    psc = 8'd2;
    cyc(0, 0, 1, 0, 26'd1);
    cyc(1, 0, 0, 0, 26'd0);
    wait_tick("psc_period", 6);
    wait_tick("psc_period", 6);
    repeat (2) step();
    cyc(0, 1, 0, 0, 26'd0);
    repeat (3) step();
    cyc(1, 0, 0, 0, 26'd0);
    wait_tick("psc_restart", 6);
    cyc(0, 1, 0, 0, 26'd0);
    psc = 8'($urandom_range(0, 3));
    cyc(1, 0, 0, 0, 26'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 39) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      ld_reload = ($urandom_range(0, 29) == 0);
      irq_ack   = ($urandom_range(0, 7) == 0);
      din       = ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'($urandom_range(0, 12));
      step();
    end
    start = 0; stop = 0; ld_reload = 0; irq_ack = 0;

    // asynchronous reset mid-count
    cyc(0, 1, 0, 0, 26'd0);
    cyc(0, 0, 1, 0, 26'd100);
    cyc(1, 0, 0, 0, 26'd0);
    repeat (63) step();
    chk("pre_reset_cnt", count, 26'd37);
    #3 resetl = 0;
    #1;
    chk("async_reset", {count, running, tick, irq_pend}, 29'd0);
    model_reset();
    @(negedge sys_clk);
    resetl = 1;
    repeat (3) step();
    chk("post_reset", {count, running}, 27'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
